// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CHECK,
        ARB_WAIT_START,
        ARB_WAIT_DONE,
        ARB_RELEASE
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, modulo N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream requesters.
// Define UART_TX_ARB_TIMEOUT_EN to enable the WAIT_START watchdog and the err_o pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_i,
    input  logic [UART_BYTE_W*N-1:0] data_i,
    input  logic [N-1:0]             last_i,
    output logic [N-1:0]             grant_o,
    output logic [N-1:0]             ack_o,
    output logic                     uart_transmit_o,
    output logic [UART_BYTE_W-1:0]   uart_tx_byte_o,
    input  logic                     uart_busy_i,
    input  logic                     cts_i,
    output logic                     err_o
);

    localparam int unsigned PtrW = $clog2(N);

    arb_state_e             state_q, state_d;
    logic [N-1:0]           grant_q, grant_d;
    logic [N-1:0]           ack_q, ack_d;
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]        gidx_q, gidx_d;
    logic [7:0]             burst_cnt_q, burst_cnt_d;
    logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic                   last_q, last_d;
    logic                   transmit_q, transmit_d;

    logic [N-1:0]           pick;
    logic [PtrW-1:0]        pick_idx;
    logic                   cur_req, cur_last;
    logic [UART_BYTE_W-1:0] cur_byte;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    rr_pick #(
        .N    (N),
        .PtrW (PtrW)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        cur_req  = 1'b0;
        cur_last = 1'b0;
        cur_byte = '0;
        pick_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gidx_q == PtrW'(i)) begin
                cur_req  = req_i[i];
                cur_last = last_i[i];
                cur_byte = data_i[i*UART_BYTE_W +: UART_BYTE_W];
            end
            if (pick[i]) begin
                pick_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ack_d       = '0;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        burst_cnt_d = burst_cnt_q;
        tx_byte_d   = tx_byte_q;
        last_d      = last_q;
        transmit_d  = transmit_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (req_i != '0 && !uart_busy_i) begin
                    grant_d     = pick;
                    gidx_d      = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ARB_CHECK;
                end
            end
            ARB_CHECK: begin
                if (!cur_req) begin
                    grant_d = '0;
                    state_d = ARB_RELEASE;
                end else if (cts_i && !uart_busy_i) begin
                    tx_byte_d  = cur_byte;
                    last_d     = cur_last;
                    ack_d      = grant_q;
                    transmit_d = 1'b1;
                    state_d    = ARB_WAIT_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            ARB_WAIT_START: begin
                if (uart_busy_i) begin
                    transmit_d = 1'b0;
                    if (burst_cnt_q < 8'(MAX_BURST)) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                    state_d = ARB_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (to_cnt_q == TimeoutLim) begin
                    // UART never took the byte: abandon the grant.
                    transmit_d = 1'b0;
                    err_d      = 1'b1;
                    grant_d    = '0;
                    state_d    = ARB_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
`endif
                end
            end
            ARB_WAIT_DONE: begin
                if (!uart_busy_i) begin
                    if (last_q || burst_cnt_q == 8'(MAX_BURST)) begin
                        grant_d = '0;
                        state_d = ARB_RELEASE;
                    end else begin
                        state_d = ARB_CHECK;
                    end
                end
            end
            ARB_RELEASE: begin
                rr_ptr_d = (gidx_q == PtrW'(N - 1)) ? '0 : gidx_q + PtrW'(1);
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            burst_cnt_q <= '0;
            tx_byte_q   <= '0;
            last_q      <= 1'b0;
            transmit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            burst_cnt_q <= burst_cnt_d;
            tx_byte_q   <= tx_byte_d;
            last_q      <= last_d;
            transmit_q  <= transmit_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign grant_o         = grant_q;
    assign ack_o           = ack_q;
    assign uart_transmit_o = transmit_q;
    assign uart_tx_byte_o  = tx_byte_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmitter among N byte-stream requesters.
- Sits between client blocks (command responder, status reporter, debug dump) and the UART transmit side.
- Sequences each byte into the UART as a transmit handshake.
- Holds a grant for a whole packet (up to MAX_BURST bytes).
- Honours CTS flow control between bytes.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255).
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  master clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  N  requester i has a byte pending on data[i].
- data  in  8*N  byte of requester i at bits [8i+7:8i]; held stable while req[i]=1.
- last  in  N  current byte of requester i ends its packet.
- grant  out  N  one-hot; requester currently owning the UART.
- ack  out  N  one-cycle pulse; byte of requester i has been accepted by the UART. Requester may change data/last on the next cycle.
- uart_transmit  out  1  transmit request to the UART.
- uart_tx_byte  out  8  byte to send.
- uart_busy  in  1  UART is_transmitting.
- cts  in  1  1 = far end clear to send.
- err  out  1  one-cycle pulse on watchdog abort (tied 0 without the feature).

Behaviour:
- Reset values: grant=0, ack=0, uart_transmit=0, uart_tx_byte=0x00, err=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- Reset mid-operation returns to IDLE on the next edge and drops grant. A byte already inside the UART finishes on its own; this block does not reset the UART.
- IDLE: if req!=0 and uart_busy=0, select the first set req[i] scanning from rr_ptr upward, modulo N. Set grant one-hot, burst_cnt=0, go to CHECK.
- CHECK:
  - If req[g]=0, go to RELEASE.
  - Else if cts=1 and uart_busy=0: latch uart_tx_byte=data[g] and last_q=last[g], pulse ack[g], assert uart_transmit, go to WAIT_START.
  - Otherwise stay in CHECK.
- WAIT_START: hold uart_transmit=1 until uart_busy=1 is sampled. Then deassert uart_transmit, burst_cnt+=1, go to WAIT_DONE.
- WAIT_DONE: wait for uart_busy=0.
  - If last_q=1 or burst_cnt==MAX_BURST, go to RELEASE.
  - Else go to CHECK.
- RELEASE: grant=0, rr_ptr=(g+1) mod N, go to IDLE. Minimum one idle cycle between grants.
- Latency from req rise (UART idle, cts=1) to uart_transmit high: 2 cycles (IDLE, then CHECK).
- Grant is never changed while uart_transmit or uart_busy is high.
- cts=0 only stalls in CHECK. A byte already launched always completes.
- req[g] dropping mid-packet ends the grant at the next CHECK; no ack is issued for it.
- Simultaneous requests: strict round robin from rr_ptr. With all N requesting, each is served once per N grants.
- burst_cnt is 8 bits and saturates at MAX_BURST; no wrap.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro: a 16-bit counter runs in WAIT_START. If uart_busy has not risen after TIMEOUT_CYCLES cycles, deassert uart_transmit, pulse err for 1 cycle and go to RELEASE. This covers a stalled UART FIFO handshake.
- Without the macro: WAIT_START waits indefinitely and err is constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - state enum ARB_IDLE, ARB_CHECK, ARB_WAIT_START, ARB_WAIT_DONE, ARB_RELEASE;
  - UART_BYTE_W=8.
- Sub-module rr_pick (combinational first-set-from-pointer selector: req, rr_ptr → one-hot) is instantiated once.

Test Plan:
- Single requester, N=4: req[2]=1, data=0x5A, last=1. Expect uart_transmit 2 cycles after req, uart_tx_byte=0x5A, ack[2] one pulse, grant[2] dropped after uart_busy falls, rr_ptr=3.
- All req=4'b1111, each sending a 1-byte packet: grant order 0,1,2,3,0; no requester served twice before all others.
- Burst of 20 bytes from req[1] with MAX_BURST=16: 16 acks, then release; grant moves to another pending requester, then req[1] finishes its remaining 4 bytes.
- cts=0 while in CHECK for 100 cycles: uart_transmit stays 0. cts→1 gives transmit on the next cycle; a byte already in flight when cts drops still completes.
- rst asserted during WAIT_DONE: next cycle grant=0, ack=0, uart_transmit=0; the arbiter stays idle until uart_busy falls.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, uart_busy held 0: err pulses once, uart_transmit drops, grant is released, rr_ptr advances.
